// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Owns the fetch PC and sequences instruction fetch for the core. It issues
//   one request at a time to instruction memory over a valid/ready request
//   channel, accepts the in-order response, and presents {pc, instr} to decode
//   through a single-entry output buffer. Taken branches and jumps from execute
//   redirect the PC. If a response is still in flight when a redirect arrives,
//   that response is squashed.
//
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_addr   fetch address (always the current pc, word aligned)
//   imem_req_ready  memory accepts the request this cycle
//   imem_rsp_valid  response for the oldest outstanding request
//   imem_rsp_data   fetched instruction
//   redirect_valid  taken branch/jump from execute
//   redirect_pc     redirect target (bits [1:0] forced to zero)
//   halt            suppress new requests
//   out_valid       decode buffer holds an instruction
//   out_pc          PC of the buffered instruction
//   out_instr       buffered instruction
//   out_ready       decode consumes the buffer this cycle
//   redirect_count  saturating count of accepted redirects
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter int unsigned          INSTR_W  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,

    output logic                imem_req_valid,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,

    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt,

    output logic                out_valid,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [INSTR_W-1:0]  out_instr,
    input  logic                out_ready,

    output logic [CNT_W-1:0]    redirect_count
);

    // BOOT  : single idle cycle after reset release
    // REQ   : offering (or ready to offer) a request at pc
    // WAIT  : one request outstanding, its response will be kept
    // FLUSH : one request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                state_q,       state_d;
    logic [PC_WIDTH-1:0]   pc_q,          pc_d;
    logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic                  req_held_q,    req_held_d;
    logic                  out_valid_q,   out_valid_d;
    logic [PC_WIDTH-1:0]   out_pc_q,      out_pc_d;
    logic [INSTR_W-1:0]    out_instr_q,   out_instr_d;
    logic [CNT_W-1:0]      redirect_count_q, redirect_count_d;

    logic                  req_valid;
    logic                  req_fire;
    logic                  rsp_keep;
    logic [PC_WIDTH-1:0]   redirect_target;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign redirect_target = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    // Request generation. A request is only started when the decode buffer is
    // empty, which guarantees a slot exists for the response. Once started,
    // req_held keeps it asserted with a stable address until accepted, so halt
    // or buffer changes cannot withdraw it. A redirect is the only thing that
    // withdraws a pending request.
    always_comb begin
        req_valid = 1'b0;
        if (state_q == ST_REQ) begin
            req_valid = (req_held_q | (~out_valid_q & ~halt)) & ~redirect_valid;
        end
    end

    assign req_fire = req_valid & imem_req_ready;

    // A response is captured only in WAIT, and only when no redirect arrives in
    // the same cycle. A same-cycle redirect makes that instruction stale.
    assign rsp_keep = (state_q == ST_WAIT) & imem_rsp_valid & ~redirect_valid;

    // Next-state and datapath. The normal FSM flow is computed first. The
    // redirect block at the end then overrides it, because a redirect takes
    // priority over everything else in every state.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inflight_pc_d    = inflight_pc_q;
        req_held_d       = req_held_q;
        out_valid_d      = out_valid_q;
        out_pc_d         = out_pc_q;
        out_instr_d      = out_instr_q;
        redirect_count_d = redirect_count_q;

        // A consume empties the buffer. A fill later in this block sets
        // out_valid again, so a same-cycle consume and fill leaves the buffer
        // valid with the new contents.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                if (req_fire) begin
                    inflight_pc_d = pc_q;
                    req_held_d    = 1'b0;
                    state_d       = ST_WAIT;
                end else if (req_valid) begin
                    req_held_d    = 1'b1;
                end
            end

            ST_WAIT: begin
                if (rsp_keep) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = inflight_pc_q;
                    out_instr_d = imem_rsp_data;
                    pc_d        = inflight_pc_q + PC_WIDTH'(4);
                    state_d     = ST_REQ;
                end
            end

            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Redirect override. The buffered instruction belongs to the wrong
        // path, so the buffer is emptied. Its contents are left untouched
        // because out_valid=0 already hides them. If a request is still
        // outstanding and its response has not arrived yet, FLUSH swallows
        // that response later.
        if (redirect_valid) begin
            pc_d        = redirect_target;
            out_valid_d = 1'b0;
            req_held_d  = 1'b0;
            if (redirect_count_q != {CNT_W{1'b1}}) begin
                redirect_count_d = redirect_count_q + CNT_W'(1);
            end
            case (state_q)
                ST_WAIT, ST_FLUSH: state_d = imem_rsp_valid ? ST_REQ : ST_FLUSH;
                default:           state_d = ST_REQ;
            endcase
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_BOOT;
            pc_q             <= RESET_PC;
            inflight_pc_q    <= '0;
            req_held_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_instr_q      <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inflight_pc_q    <= inflight_pc_d;
            req_held_q       <= req_held_d;
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_instr_q      <= out_instr_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_instr      = out_instr_q;
    assign redirect_count = redirect_count_q;

endmodule
